fetch_control: RTL and testbench

Pipeline control unit that drives the fetch stage's control inputs: `load_pc`, `load_if_id_register`, `if_flush`, `mux_sel` and `pc_branch_value`. It detects load-use hazards between ID and EX, applies taken-branch redirects resolved in EX, holds fetch idle for a programmable number of cycles after reset, and supports an external halt. It sits beside the IF and ID stages and is the producer for every control input the fetch stage consumes. It also keeps saturating stall and flush counters for bench and debug visibility.

---
 rtl/fetch_control.sv | 130 +++++++++++++
 tb/tb_fetch_control.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_control.sv
// Fetch-stage control: load-use stalls, EX branch redirects,
// post-reset fetch hold, external halt, and stall/flush counters.
module fetch_control #(
    parameter int RESET_HOLD = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             halt,
    input  logic             ex_branch_taken,
    input  logic [31:0]      ex_branch_target,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    output logic             load_pc,
    output logic             load_if_id_register,
    output logic             if_flush,
    output logic             mux_sel,
    output logic [31:0]      pc_branch_value,
    output logic             id_ex_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int HW = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST =
        HW'((RESET_HOLD > 0) ? RESET_HOLD - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        HALTED
    } state_t;

    localparam state_t START = (RESET_HOLD > 0) ? HOLD : RUN;

    state_t          state;
    state_t          state_nxt;
    logic [HW-1:0]   hold_cnt;
    logic [HW-1:0]   hold_cnt_nxt;
    logic            load_use;
    logic            stall_evt;
    logic            flush_evt;

    always_comb begin
        load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                   ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= START;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt           = state;
        hold_cnt_nxt        = hold_cnt;
        load_pc             = 1'b0;
        load_if_id_register = 1'b0;
        if_flush            = 1'b0;
        mux_sel             = 1'b0;
        id_ex_bubble        = 1'b0;
        stall_evt           = 1'b0;
        flush_evt           = 1'b0;
        unique case (state)
            HOLD: begin
                if_flush     = 1'b1;
                id_ex_bubble = 1'b1;
                hold_cnt_nxt = hold_cnt + 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                load_pc             = 1'b1;
                load_if_id_register = 1'b1;
                // A taken branch flushes ID, so its hazard is moot.
                if (ex_branch_taken) begin
                    mux_sel      = 1'b1;
                    if_flush     = 1'b1;
                    id_ex_bubble = 1'b1;
                    flush_evt    = 1'b1;
                end else if (load_use) begin
                    load_pc             = 1'b0;
                    load_if_id_register = 1'b0;
                    id_ex_bubble        = 1'b1;
                    stall_evt           = 1'b1;
                end
                if (halt) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                id_ex_bubble = 1'b1;
                if (!halt) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = START;
            end
        endcase
    end

    always_comb begin
        pc_branch_value = mux_sel ? ex_branch_target : 32'd0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_evt && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + 1'b1;
            end
            if (flush_evt && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control: abstract cycle model plus
// hand-computed expectations; a second instance exercises saturation.
module tb_fetch_control;

    logic        clock = 1'b0;
    logic        reset;
    logic        halt;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rd;
    logic [4:0]  if_id_rs1;
    logic [4:0]  if_id_rs2;

    logic        load_pc;
    logic        load_if_id_register;
    logic        if_flush;
    logic        mux_sel;
    logic [31:0] pc_branch_value;
    logic        id_ex_bubble;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    logic        s_load_pc;
    logic        s_load_if_id_register;
    logic        s_if_flush;
    logic        s_mux_sel;
    logic [31:0] s_pc_branch_value;
    logic        s_id_ex_bubble;
    logic [1:0]  s_stall_count;
    logic [1:0]  s_flush_count;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    fetch_control u_dut (
        .clock               (clock),
        .reset               (reset),
        .halt                (halt),
        .ex_branch_taken     (ex_branch_taken),
        .ex_branch_target    (ex_branch_target),
        .id_ex_mem_read      (id_ex_mem_read),
        .id_ex_rd            (id_ex_rd),
        .if_id_rs1           (if_id_rs1),
        .if_id_rs2           (if_id_rs2),
        .load_pc             (load_pc),
        .load_if_id_register (load_if_id_register),
        .if_flush            (if_flush),
        .mux_sel             (mux_sel),
        .pc_branch_value     (pc_branch_value),
        .id_ex_bubble        (id_ex_bubble),
        .stall_count         (stall_count),
        .flush_count         (flush_count)
    );

    fetch_control #(.RESET_HOLD(2), .CNT_W(2)) u_sat (
        .clock               (clock),
        .reset               (reset),
        .halt                (halt),
        .ex_branch_taken     (ex_branch_taken),
        .ex_branch_target    (ex_branch_target),
        .id_ex_mem_read      (id_ex_mem_read),
        .id_ex_rd            (id_ex_rd),
        .if_id_rs1           (if_id_rs1),
        .if_id_rs2           (if_id_rs2),
        .load_pc             (s_load_pc),
        .load_if_id_register (s_load_if_id_register),
        .if_flush            (s_if_flush),
        .mux_sel             (s_mux_sel),
        .pc_branch_value     (s_pc_branch_value),
        .id_ex_bubble        (s_id_ex_bubble),
        .stall_count         (s_stall_count),
        .flush_count         (s_flush_count)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: cycles of fetch hold left, halted flag, event tallies.
    bit m_valid = 0;
    int m_hold;
    bit m_halted;
    int m_stall;
    int m_flush;

    function automatic bit lu_now();
        return id_ex_mem_read && id_ex_rd != 0 &&
               (id_ex_rd == if_id_rs1 || id_ex_rd == if_id_rs2);
    endfunction

    function automatic int cap(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            m_valid  = 1;
            m_hold   = 2;
            m_halted = 0;
            m_stall  = 0;
            m_flush  = 0;
        end else if (m_valid) begin
            if (m_hold > 0) begin
                m_hold--;
            end else if (m_halted) begin
                if (!halt) m_halted = 0;
            end else begin
                if (ex_branch_taken) m_flush++;
                else if (lu_now()) m_stall++;
                if (halt) m_halted = 1;
            end
        end
    end

    logic        e_lpc, e_lif, e_fl, e_mux, e_bub;
    logic [31:0] e_pbv;

    always @(negedge clock) begin
        if (m_valid) begin
            if (m_hold > 0) begin
                {e_lpc, e_lif, e_fl, e_mux, e_bub} = 5'b00101;
            end else if (m_halted) begin
                {e_lpc, e_lif, e_fl, e_mux, e_bub} = 5'b00001;
            end else if (ex_branch_taken) begin
                {e_lpc, e_lif, e_fl, e_mux, e_bub} = 5'b11111;
            end else if (lu_now()) begin
                {e_lpc, e_lif, e_fl, e_mux, e_bub} = 5'b00001;
            end else begin
                {e_lpc, e_lif, e_fl, e_mux, e_bub} = 5'b11000;
            end
            e_pbv = e_mux ? ex_branch_target : 32'd0;
            chk("load_pc", {31'd0, load_pc}, {31'd0, e_lpc});
            chk("load_if_id", {31'd0, load_if_id_register},
                {31'd0, e_lif});
            chk("if_flush", {31'd0, if_flush}, {31'd0, e_fl});
            chk("mux_sel", {31'd0, mux_sel}, {31'd0, e_mux});
            chk("id_ex_bubble", {31'd0, id_ex_bubble}, {31'd0, e_bub});
            chk("pc_branch_value", pc_branch_value, e_pbv);
            chk("stall_count", {16'd0, stall_count},
                cap(m_stall, 65535));
            chk("flush_count", {16'd0, flush_count},
                cap(m_flush, 65535));
            chk("sat_load_pc", {31'd0, s_load_pc}, {31'd0, e_lpc});
            chk("sat_stall_count", {30'd0, s_stall_count},
                cap(m_stall, 3));
            chk("sat_flush_count", {30'd0, s_flush_count},
                cap(m_flush, 3));
        end
    end

    task automatic drive(input logic br, input logic [31:0] tgt,
                         input logic mr, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic h);
        ex_branch_taken  = br;
        ex_branch_target = tgt;
        id_ex_mem_read   = mr;
        id_ex_rd         = rd;
        if_id_rs1        = r1;
        if_id_rs2        = r2;
        halt             = h;
    endtask

    task automatic idle();
        drive(0, 32'h0, 0, 0, 0, 0, 0);
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        idle();
        next();
        next();
        reset = 1'b1;

        // Two held cycles after release, then RUN.
        @(negedge clock);
        chk("hold1_load_pc", {31'd0, load_pc}, 32'd0);
        chk("hold1_if_flush", {31'd0, if_flush}, 32'd1);
        next();
        @(negedge clock);
        chk("hold2_load_pc", {31'd0, load_pc}, 32'd0);
        next();
        @(negedge clock);
        chk("run_load_pc", {31'd0, load_pc}, 32'd1);
        chk("run_mux_sel", {31'd0, mux_sel}, 32'd0);
        chk("run_stall0", {16'd0, stall_count}, 32'd0);
        chk("run_flush0", {16'd0, flush_count}, 32'd0);
        next();

        drive(1, 32'h10, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("br_mux_sel", {31'd0, mux_sel}, 32'd1);
        chk("br_pbv", pc_branch_value, 32'h10);
        chk("br_if_flush", {31'd0, if_flush}, 32'd1);
        chk("br_bubble", {31'd0, id_ex_bubble}, 32'd1);
        next();
        idle();
        @(negedge clock);
        chk("br_flush1", {16'd0, flush_count}, 32'd1);
        next();

        drive(0, 32'h0, 1, 5, 1, 5, 0);
        @(negedge clock);
        chk("lu_load_pc", {31'd0, load_pc}, 32'd0);
        chk("lu_load_if_id", {31'd0, load_if_id_register}, 32'd0);
        chk("lu_bubble", {31'd0, id_ex_bubble}, 32'd1);
        next();
        drive(0, 32'h0, 1, 0, 0, 0, 0);
        @(negedge clock);
        chk("lu_stall1", {16'd0, stall_count}, 32'd1);
        chk("rd0_load_pc", {31'd0, load_pc}, 32'd1);
        next();
        drive(0, 32'h0, 1, 3, 3, 9, 0);
        @(negedge clock);
        chk("lu_rs1_load_pc", {31'd0, load_pc}, 32'd0);
        next();

        // Branch wins over a simultaneous load-use.
        drive(1, 32'h20, 1, 6, 6, 6, 0);
        @(negedge clock);
        chk("both_mux_sel", {31'd0, mux_sel}, 32'd1);
        chk("both_load_pc", {31'd0, load_pc}, 32'd1);
        next();
        idle();
        @(negedge clock);
        chk("both_flush2", {16'd0, flush_count}, 32'd2);
        chk("both_stall2", {16'd0, stall_count}, 32'd2);
        next();

        drive(1, 32'h40, 0, 0, 0, 0, 1);
        @(negedge clock);
        chk("hb_mux_sel", {31'd0, mux_sel}, 32'd1);
        chk("hb_pbv", pc_branch_value, 32'h40);
        next();
        drive(1, 32'h80, 1, 5, 5, 0, 1);
        @(negedge clock);
        chk("halt1_load_pc", {31'd0, load_pc}, 32'd0);
        chk("halt1_mux_sel", {31'd0, mux_sel}, 32'd0);
        chk("halt1_pbv", pc_branch_value, 32'd0);
        chk("halt1_flush3", {16'd0, flush_count}, 32'd3);
        next();
        drive(0, 32'h0, 0, 0, 0, 0, 1);
        @(negedge clock);
        chk("halt2_load_pc", {31'd0, load_pc}, 32'd0);
        next();
        idle();
        @(negedge clock);
        chk("halt3_load_pc", {31'd0, load_pc}, 32'd0);
        next();
        @(negedge clock);
        chk("resume_load_pc", {31'd0, load_pc}, 32'd1);
        next();

        for (int i = 0; i < 5; i++) begin
            drive(0, 32'h0, 1, 7, 7, 0, 0);
            next();
        end
        idle();
        @(negedge clock);
        chk("stall7", {16'd0, stall_count}, 32'd7);
        chk("sat_stall3", {30'd0, s_stall_count}, 32'd3);
        chk("sat_flush3", {30'd0, s_flush_count}, 32'd3);
        next();

        drive(0, 32'h0, 0, 0, 0, 0, 1);
        next();
        reset = 1'b0;
        @(negedge clock);
        chk("pre_rst_sat_stall", {30'd0, s_stall_count}, 32'd3);
        next();
        reset = 1'b1;
        idle();
        @(negedge clock);
        chk("post_rst_load_pc", {31'd0, load_pc}, 32'd0);
        chk("post_rst_if_flush", {31'd0, if_flush}, 32'd1);
        chk("post_rst_stall", {16'd0, stall_count}, 32'd0);
        chk("post_rst_flush", {16'd0, flush_count}, 32'd0);
        chk("post_rst_sat_stall", {30'd0, s_stall_count}, 32'd0);
        next();
        next();
        @(negedge clock);
        chk("post_rst_run", {31'd0, load_pc}, 32'd1);
        next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
